// File: rtl/etapa_ex_pkg.sv
// ============================================================================
// etapa_ex_pkg : codes shared by the EX stage, etapa_mem and the hazard unit
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package etapa_ex_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CTRL_W = 4;

    localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0011;
    localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [CTRL_W-1:0] ALU_NOR  = 4'b0101;
    localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0110;
    localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b0111;
    localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b1000;
    localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b1001;
    localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b1010;
    localparam logic [CTRL_W-1:0] ALU_SLLV = 4'b1011;
    localparam logic [CTRL_W-1:0] ALU_SRLV = 4'b1100;
    localparam logic [CTRL_W-1:0] ALU_SRAV = 4'b1101;
    localparam logic [CTRL_W-1:0] ALU_LUI  = 4'b1110;
    localparam logic [CTRL_W-1:0] ALU_ZERO = 4'b1111;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [1:0] BHW_BYTE = 2'b00;
    localparam logic [1:0] BHW_HALF = 2'b01;
    localparam logic [1:0] BHW_WORD = 2'b11;

    localparam logic [REG_W-1:0] LINK_REG = 5'd31;

    typedef struct packed {
        logic       wb_write;
        logic       wb_mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       mem_unsigned;
        logic [1:0] byte_half_word;
    } ex_ctrl_t;

    // The unused select code 11 falls back to the register value.
    function automatic logic [DATA_W-1:0] fwd_select(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] reg_val,
        input logic [DATA_W-1:0] mem_val,
        input logic [DATA_W-1:0] wb_val
    );
        case (sel)
            FWD_MEM: fwd_select = mem_val;
            FWD_WB:  fwd_select = wb_val;
            default: fwd_select = reg_val;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/etapa_ex_alu.sv
// ============================================================================
// etapa_ex_alu : combinational ALU of the EX stage
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module etapa_ex_alu
    import etapa_ex_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [REG_W-1:0]  shamt,
    input  logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] result
);

    logic [REG_W-1:0] var_shamt;

    assign var_shamt = a[REG_W-1:0];

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {31'd0, (a < b)};
            ALU_SLL:  result = b << shamt;
            ALU_SRL:  result = b >> shamt;
            ALU_SRA:  result = $unsigned($signed(b) >>> shamt);
            ALU_SLLV: result = b << var_shamt;
            ALU_SRLV: result = b >> var_shamt;
            ALU_SRAV: result = $unsigned($signed(b) >>> var_shamt);
            ALU_LUI:  result = {b[15:0], 16'd0};
            default:  result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/etapa_ex.sv
// ============================================================================
// etapa_ex : execute stage -- operand forwarding, ALU and EX/MEM register
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module etapa_ex
    import etapa_ex_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_halt,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_rs_data,
    input  logic [DATA_W-1:0] i_rt_data,
    input  logic [DATA_W-1:0] i_immediate,
    input  logic [DATA_W-1:0] i_pc_plus_8,
    input  logic [REG_W-1:0]  i_shamt,
    input  logic [REG_W-1:0]  i_rt,
    input  logic [REG_W-1:0]  i_rd,
    input  logic [CTRL_W-1:0] i_ALU_ctrl,
    input  logic              i_ALU_src,
    input  logic              i_reg_dst,
    input  logic              i_link,
    input  logic [1:0]        i_fwd_a,
    input  logic [1:0]        i_fwd_b,
    input  logic [DATA_W-1:0] i_MEM_fwd_data,
    input  logic [DATA_W-1:0] i_WB_fwd_data,
    input  logic              i_WB_write,
    input  logic              i_WB_mem_to_reg,
    input  logic              i_MEM_read,
    input  logic              i_MEM_write,
    input  logic              i_MEM_unsigned,
    input  logic [1:0]        i_MEM_byte_half_word,
    output logic [DATA_W-1:0] o_ALU_result,
    output logic [DATA_W-1:0] o_data_to_write_in_MEM,
    output logic [REG_W-1:0]  o_write_reg,
    output logic              o_WB_write,
    output logic              o_WB_mem_to_reg,
    output logic              o_MEM_read,
    output logic              o_MEM_write,
    output logic              o_MEM_unsigned,
    output logic [1:0]        o_MEM_byte_half_word
);

    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b_fwd;
    logic [DATA_W-1:0] operand_b;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] result_next;
    logic [REG_W-1:0]  dest_next;
    ex_ctrl_t          ctrl_next;

    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] store_q;
    logic [REG_W-1:0]  dest_q;
    ex_ctrl_t          ctrl_q;

    assign operand_a     = fwd_select(i_fwd_a, i_rs_data, i_MEM_fwd_data, i_WB_fwd_data);
    assign operand_b_fwd = fwd_select(i_fwd_b, i_rt_data, i_MEM_fwd_data, i_WB_fwd_data);
    // Store data is taken before the immediate mux so SW always writes rt.
    assign operand_b     = i_ALU_src ? i_immediate : operand_b_fwd;

    etapa_ex_alu alu (
        .a      (operand_a),
        .b      (operand_b),
        .shamt  (i_shamt),
        .ctrl   (i_ALU_ctrl),
        .result (alu_out)
    );

    assign result_next = i_link ? i_pc_plus_8 : alu_out;
    assign dest_next   = (i_link && !i_reg_dst) ? LINK_REG
                       : (i_reg_dst ? i_rd : i_rt);

    assign ctrl_next = '{
        wb_write:       i_WB_write,
        wb_mem_to_reg:  i_WB_mem_to_reg,
        mem_read:       i_MEM_read,
        mem_write:      i_MEM_write,
        mem_unsigned:   i_MEM_unsigned,
        byte_half_word: i_MEM_byte_half_word
    };

    // Halt wins over flush so the debug unit sees a frozen pipeline.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            result_q <= '0;
            store_q  <= '0;
            dest_q   <= '0;
            ctrl_q   <= '0;
        end else if (i_halt) begin
            result_q <= result_q;
            store_q  <= store_q;
            dest_q   <= dest_q;
            ctrl_q   <= ctrl_q;
        end else if (i_flush) begin
            result_q <= '0;
            store_q  <= '0;
            dest_q   <= '0;
            ctrl_q   <= '0;
        end else begin
            result_q <= result_next;
            store_q  <= operand_b_fwd;
            dest_q   <= dest_next;
            ctrl_q   <= ctrl_next;
        end
    end

    assign o_ALU_result           = result_q;
    assign o_data_to_write_in_MEM = store_q;
    assign o_write_reg            = dest_q;
    assign o_WB_write             = ctrl_q.wb_write;
    assign o_WB_mem_to_reg        = ctrl_q.wb_mem_to_reg;
    assign o_MEM_read             = ctrl_q.mem_read;
    assign o_MEM_write            = ctrl_q.mem_write;
    assign o_MEM_unsigned         = ctrl_q.mem_unsigned;
    assign o_MEM_byte_half_word   = ctrl_q.byte_half_word;

endmodule

`default_nettype wire

// File: doc/etapa_ex.md
ETAPA_EX -- requirements
Module: etapa_ex

Interface
REQ-001 Parameter: none; widths fixed (data 32, register index 5, ALU control 4).
REQ-002 i_clk  in  1  single clock; all state on rising edge.
REQ-003 i_reset_n  in  1  asynchronous, active-low reset.
REQ-004 i_halt  in  1  freeze stage (debug unit); i_flush  in  1  insert bubble.
REQ-005 i_rs_data, i_rt_data  in  32  register operands from ID/EX; i_immediate  in  32  sign/zero-extended immediate; i_pc_plus_8  in  32  JAL/JALR link value.
REQ-006 i_shamt, i_rt, i_rd  in  5  shift amount and register indices.
REQ-007 i_ALU_ctrl  in  4  operation; i_ALU_src  in  1  (0 rt, 1 immediate); i_reg_dst  in  1  (0 rt, 1 rd); i_link  in  1  (1: result = i_pc_plus_8, dest = 31 when i_reg_dst=0).
REQ-008 i_fwd_a, i_fwd_b  in  2  forwarding selects; i_MEM_fwd_data, i_WB_fwd_data  in  32  forwarded values.
REQ-009 i_WB_write, i_WB_mem_to_reg, i_MEM_read, i_MEM_write, i_MEM_unsigned  in  1; i_MEM_byte_half_word  in  2  pass-through control.
REQ-010 o_ALU_result, o_data_to_write_in_MEM  out  32; o_write_reg  out  5; registered.
REQ-011 o_WB_write, o_WB_mem_to_reg, o_MEM_read, o_MEM_write, o_MEM_unsigned  out  1; o_MEM_byte_half_word  out  2; registered copies of control.

Function
REQ-012 Operand A = i_fwd_a: 00 i_rs_data, 01 i_MEM_fwd_data, 10 i_WB_fwd_data, 11 i_rs_data; operand B' selected identically from i_rt_data via i_fwd_b.
REQ-013 Store data = B' (post-forwarding, pre-immediate mux); ALU B = i_ALU_src ? i_immediate : B'.
REQ-014 ALU ops: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOR, 0110 SLT signed, 0111 SLTU, 1000 SLL B by i_shamt, 1001 SRL by i_shamt, 1010 SRA by i_shamt, 1011 SLLV by A[4:0], 1100 SRLV, 1101 SRAV, 1110 LUI (B[15:0]<<16), 1111 result 0.
REQ-015 ADD/SUB wrap modulo 2^32; no overflow flag, no trap.
REQ-016 SLT/SLTU result 32'h1 or 32'h0.
REQ-017 Destination = i_link & !i_reg_dst ? 31 : (i_reg_dst ? i_rd : i_rt); result = i_link ? i_pc_plus_8 : ALU output.
REQ-018 Latency: one cycle; inputs at edge N appear on outputs after edge N; no stalls generated.
REQ-019 i_halt=1: all output registers hold; takes precedence over i_flush.
REQ-020 i_flush=1 and i_halt=0: next edge loads bubble -- all control outputs 0, data outputs 0, o_write_reg 0.
REQ-021 Normal (neither asserted): all outputs load computed values every edge.
REQ-022 Combinational path restricted to operand muxes and ALU; no combinational input-to-output path.

Reset
REQ-023 i_reset_n low: all outputs 0 immediately, independent of i_clk, i_halt, i_flush.
REQ-024 Release: first rising edge with i_reset_n high loads inputs per REQ-019..021.

Structure
REQ-025 Shared package holds ALU control codes, forwarding select codes (REG/MEM/WB) and byte/half/word codes (00/01/11) shared with etapa_mem and hazard unit.
REQ-026 ALU in sub-module alu (pure combinational: A, B, shamt, ctrl -> result); operand muxes and pipeline register in etapa_ex.

Verification
REQ-027 rs=5, imm=-3, ALU_src=1, ADD, reg_dst=0, rt=7 -> o_ALU_result=2, o_write_reg=7 after one edge.
REQ-028 fwd_a=01, MEM_fwd=0x10, fwd_b=10, WB_fwd=0x3, SUB, ALU_src=0 -> result 0x0D; o_data_to_write_in_MEM=0x3.
REQ-029 SLT A=0xFFFFFFFF, B=1 -> 1; SLTU same -> 0; SRA B=0x80000000 shamt=4 -> 0xF8000000; LUI imm=0x1234 -> 0x12340000.
REQ-030 i_link=1, reg_dst=0, pc_plus_8=0x40 -> result 0x40, write_reg 31.
REQ-031 Load outputs, assert i_halt 3 cycles with changing inputs -> outputs unchanged; halt+flush together -> unchanged; flush alone -> all control outputs 0 next edge.
REQ-032 Assert i_reset_n low mid-cycle with nonzero outputs -> all outputs 0 before next edge; release -> normal loading resumes next edge.
